// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key schedule and the round datapath.
//   - aes_word_t / aes_block_t : 32-bit word and 128-bit block types
//   - aes_num_rounds_lp        : number of AES-128 rounds (10)
//   - aes_rcon_init_lp         : Rcon value used for round 1
//   - rkg_state_e              : round_key_gen FSM states
//   - xtime / gf_mul / aes_sbox: GF(2^8) helpers and the forward S-box
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam int        aes_num_rounds_lp = 10;
    localparam logic [7:0] aes_rcon_init_lp = 8'h01;

    typedef enum logic {
        e_idle = 1'b0,
        e_run  = 1'b1
    } rkg_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (b^254, with 0 -> 0) followed by
    // the FIPS-197 affine transform. The loop builds b^(2^k - 1) up to
    // b^127, and a final square gives b^254.
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] s;
        p = b;
        for (int i = 0; i < 6; i++) begin
            p = gf_mul(gf_mul(p, p), b);
        end
        p = gf_mul(p, p);
        s = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
        return s;
    endfunction

endpackage

// File: rtl/round_key_gen_if.sv
// ----------------------------------------------------------------------------
// round_key_gen_if
// Key-in / round-key-out bus of round_key_gen.
//   key_i, v_i, ready_o         : cipher key input, transfers on v_i & ready_o
//   round_key_o, round_o, v_o   : current round key, its index, valid
//   yumi_i                      : consumer takes the current round key
// Modports: slave = round_key_gen side, master = upstream/consumer side.
// ----------------------------------------------------------------------------
interface round_key_gen_if;
    import aes_pkg::*;

    aes_block_t key_i;
    logic       v_i;
    logic       ready_o;
    aes_block_t round_key_o;
    logic [3:0] round_o;
    logic       v_o;
    logic       yumi_i;

    modport slave (
        input  key_i, v_i, yumi_i,
        output ready_o, round_key_o, round_o, v_o
    );

    modport master (
        output key_i, v_i, yumi_i,
        input  ready_o, round_key_o, round_o, v_o
    );

endinterface

// File: rtl/key_sched_step.sv
// ----------------------------------------------------------------------------
// key_sched_step
// One combinational AES-128 key expansion step.
//   i_key  : current round key, w0 = i_key[127:96]
//   i_rcon : round constant for the key being produced
//   o_key  : next round key
// ----------------------------------------------------------------------------
module key_sched_step
    import aes_pkg::*;
(
    input  aes_block_t i_key,
    input  logic [7:0] i_rcon,
    output aes_block_t o_key
);

    aes_word_t w_w0, w_w1, w_w2, w_w3;
    aes_word_t w_rot, w_sub, w_t;
    aes_word_t w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_key[127:96];
    assign w_w1 = i_key[95:64];
    assign w_w2 = i_key[63:32];
    assign w_w3 = i_key[31:0];

    // RotWord: byte 0 (MSB) moves to the least-significant byte.
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    sub_bytes #(.NUM_BYTES(4)) u_sub_word (
        .i_data (w_rot),
        .o_data (w_sub)
    );

    assign w_t  = w_sub ^ {i_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/sub_bytes.sv
// ----------------------------------------------------------------------------
// sub_bytes
// Combinational AES SubBytes over NUM_BYTES bytes.
//   i_data : NUM_BYTES input bytes
//   o_data : S-box of each byte, same byte positions
// ----------------------------------------------------------------------------
module sub_bytes
    import aes_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic [8*NUM_BYTES-1:0] i_data,
    output logic [8*NUM_BYTES-1:0] o_data
);

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_sbox
        assign o_data[8*g +: 8] = aes_sbox(i_data[8*g +: 8]);
    end

endmodule

// File: rtl/round_key_gen.sv
// ----------------------------------------------------------------------------
// round_key_gen
// Iterative AES-128 key schedule: accepts one cipher key and streams round
// keys 0..10, one per consumer yumi, computing each key on the fly.
//   clk_i       : clock
//   reset_i     : synchronous active-high reset
//   bus         : round_key_gen_if.slave (key in, round key out)
//   dbg_state_o : current FSM state, for observation only
//
// Handshake: a key transfers on the rising edge where v_i & ready_o; ready_o
// is high only in IDLE. A round key is offered while v_o is high (RUN) and is
// consumed on the edge where yumi_i is high; round_key_o/round_o stay
// unchanged until then. yumi_i with v_o low and v_i with ready_o low are
// ignored. All outputs come straight from registers.
// ----------------------------------------------------------------------------
module round_key_gen
    import aes_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    round_key_gen_if.slave        bus,
    output rkg_state_e            dbg_state_o
);

    localparam logic [3:0] last_round_lp = 4'(aes_num_rounds_lp);

    rkg_state_e r_state;
    aes_block_t r_key;
    logic [3:0] r_round;
    logic [7:0] r_rcon;

    rkg_state_e w_state_nxt;
    aes_block_t w_key_nxt;
    logic [3:0] w_round_nxt;
    logic [7:0] w_rcon_nxt;
    aes_block_t w_step_key;

    key_sched_step u_step (
        .i_key  (r_key),
        .i_rcon (r_rcon),
        .o_key  (w_step_key)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= aes_rcon_init_lp;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_round <= w_round_nxt;
            r_rcon  <= w_rcon_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_round_nxt = r_round;
        w_rcon_nxt  = r_rcon;
        case (r_state)
            e_idle: begin
                if (bus.v_i) begin
                    w_key_nxt   = bus.key_i;
                    w_round_nxt = '0;
                    w_rcon_nxt  = aes_rcon_init_lp;
                    w_state_nxt = e_run;
                end
            end
            e_run: begin
                if (bus.yumi_i) begin
                    // The last key leaves key_r/round_r untouched so the
                    // final values stay visible after the stream ends.
                    if (r_round == last_round_lp) begin
                        w_state_nxt = e_idle;
                    end else begin
                        w_key_nxt   = w_step_key;
                        w_round_nxt = r_round + 4'd1;
                        w_rcon_nxt  = xtime(r_rcon);
                    end
                end
            end
            default: begin
                w_state_nxt = e_idle;
            end
        endcase
    end

    assign bus.ready_o     = (r_state == e_idle);
    assign bus.v_o         = (r_state == e_run);
    assign bus.round_key_o = r_key;
    assign bus.round_o     = r_round;
    assign dbg_state_o     = r_state;

endmodule
